// File: rtl/sync_edge_event_queue.sv
// Glitch filter and edge detector for a synchronized level.
// Edges are queued as {polarity, timestamp} events in a show-ahead FIFO.
module sync_edge_event_queue #(
    parameter int FILTER_LEN = 4,
    parameter int TS_W       = 16,
    parameter int DEPTH      = 8,
    parameter int OVF_W      = 8
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     sync_in,
    output logic                     evt_valid,
    input  logic                     evt_ready,
    output logic                     evt_rise,
    output logic [TS_W-1:0]          evt_ts,
    output logic                     level_out,
    output logic [$clog2(DEPTH):0]   fifo_count,
    output logic [OVF_W-1:0]         overflow_cnt,
    input  logic                     ovf_clr
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;
    localparam int SW = $clog2(FILTER_LEN + 1);
    localparam logic [SW-1:0]    STAB_MAX = SW'(FILTER_LEN - 1);
    localparam logic [CW-1:0]    FULL_CNT = CW'(DEPTH);
    localparam logic [OVF_W-1:0] OVF_MAX  = '1;

    logic [TS_W-1:0] ts;
    logic [SW-1:0]   stab_cnt;
    logic [TS_W:0]   mem [DEPTH];
    logic [AW-1:0]   wptr;
    logic [AW-1:0]   rptr;
    logic [CW-1:0]   count;

    logic commit;
    logic pop;
    logic full;
    logic wr;
    logic drop;

    assign commit = (sync_in != level_out) && (stab_cnt == STAB_MAX);
    assign full   = (count == FULL_CNT);
    assign pop    = evt_valid && evt_ready;
    // A full FIFO still accepts a push when the head leaves in the same cycle.
    assign wr     = commit && (!full || pop);
    assign drop   = commit && full && !pop;

    assign evt_valid  = (count != '0);
    assign evt_rise   = evt_valid && mem[rptr][TS_W];
    assign evt_ts     = evt_valid ? mem[rptr][TS_W-1:0] : '0;
    assign fifo_count = count;

    always_ff @(posedge clk) begin
        if (rst) begin
            ts        <= '0;
            level_out <= 1'b0;
            stab_cnt  <= '0;
        end else begin
            ts <= ts + 1'b1;
            if (sync_in == level_out) begin
                stab_cnt <= '0;
            end else if (commit) begin
                level_out <= sync_in;
                stab_cnt  <= '0;
            end else begin
                stab_cnt <= stab_cnt + 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (wr) begin
            mem[wptr] <= {sync_in, ts};
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wptr  <= '0;
            rptr  <= '0;
            count <= '0;
        end else begin
            if (wr) begin
                wptr <= wptr + 1'b1;
            end
            if (pop) begin
                rptr <= rptr + 1'b1;
            end
            case ({wr, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            overflow_cnt <= '0;
        end else if (ovf_clr) begin
            overflow_cnt <= drop ? OVF_W'(1) : '0;
        end else if (drop && overflow_cnt != OVF_MAX) begin
            overflow_cnt <= overflow_cnt + 1'b1;
        end
    end

endmodule

// File: tb/tb_sync_edge_event_queue.sv
// Directed bench for sync_edge_event_queue: a default instance plus a
// TS_W=4 instance driven by the same stimulus to observe timestamp wrap.
module tb_sync_edge_event_queue;
    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        sync_in = 1'b0;
    logic        evt_ready = 1'b0;
    logic        ovf_clr = 1'b0;

    logic        evt_valid;
    logic        evt_rise;
    logic [15:0] evt_ts;
    logic        level_out;
    logic [3:0]  fifo_count;
    logic [7:0]  overflow_cnt;

    logic        s_valid;
    logic        s_rise;
    logic [3:0]  s_ts;
    logic        s_level;
    logic [3:0]  s_count;
    logic [7:0]  s_ovf;

    int          n_cmp = 0;
    int          n_bad = 0;
    logic [15:0] tts = '0;
    logic [15:0] q [10];
    logic [15:0] dummy;

    always #5 clk = ~clk;

    sync_edge_event_queue u_dut (
        .clk(clk), .rst(rst), .sync_in(sync_in),
        .evt_valid(evt_valid), .evt_ready(evt_ready),
        .evt_rise(evt_rise), .evt_ts(evt_ts),
        .level_out(level_out), .fifo_count(fifo_count),
        .overflow_cnt(overflow_cnt), .ovf_clr(ovf_clr)
    );

    sync_edge_event_queue #(.TS_W(4)) u_small (
        .clk(clk), .rst(rst), .sync_in(sync_in),
        .evt_valid(s_valid), .evt_ready(evt_ready),
        .evt_rise(s_rise), .evt_ts(s_ts),
        .level_out(s_level), .fifo_count(s_count),
        .overflow_cnt(s_ovf), .ovf_clr(ovf_clr)
    );

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Inputs change and outputs are sampled on the falling edge.
    task automatic tick();
        @(negedge clk);
        tts = tts + 16'd1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        tts = '0;
    endtask

    // One filtered edge: toggle input and hold it FILTER_LEN cycles.
    task automatic edge_evt(input logic rdy, input logic clr,
                            output logic [15:0] cts);
        sync_in = ~sync_in;
        cts = tts + 16'd3;
        repeat (3) tick();
        evt_ready = rdy;
        ovf_clr = clr;
        tick();
        evt_ready = 1'b0;
        ovf_clr = 1'b0;
    endtask

    initial begin
        // 1) reset and idle
        do_reset();
        chk("rst_valid", 32'(evt_valid), 0);
        chk("rst_count", 32'(fifo_count), 0);
        chk("rst_level", 32'(level_out), 0);
        chk("rst_ovf", 32'(overflow_cnt), 0);
        chk("rst_ts", 32'(evt_ts), 0);
        chk("rst_rise", 32'(evt_rise), 0);
        for (int i = 0; i < 100; i++) begin
            chk("idle", {evt_valid, level_out, fifo_count, overflow_cnt}, 0);
            tick();
        end

        // 2) rise at ts=10, commit at 13, visible at 14
        do_reset();
        evt_ready = 1'b1;
        repeat (10) tick();
        sync_in = 1'b1;
        tick();
        chk("t2_lvl11", 32'(level_out), 0);
        tick();
        tick();
        chk("t2_lvl13", 32'(level_out), 0);
        chk("t2_val13", 32'(evt_valid), 0);
        tick();
        chk("t2_lvl14", 32'(level_out), 1);
        chk("t2_val14", 32'(evt_valid), 1);
        chk("t2_rise14", 32'(evt_rise), 1);
        chk("t2_ts14", 32'(evt_ts), 13);
        chk("t2_sts14", 32'(s_ts), 13);
        tick();
        chk("t2_val15", 32'(evt_valid), 0);
        chk("t2_lvl15", 32'(level_out), 1);

        // 3) short pulse rejected, 4-cycle pulse accepted
        sync_in = 1'b0;
        do_reset();
        sync_in = 1'b1;
        repeat (3) tick();
        sync_in = 1'b0;
        for (int i = 0; i < 8; i++) begin
            chk("t3_glitch", {level_out, evt_valid}, 0);
            tick();
        end
        dummy = tts;
        sync_in = 1'b1;
        repeat (4) tick();
        sync_in = 1'b0;
        chk("t3_rlvl", 32'(level_out), 1);
        chk("t3_rval", 32'(evt_valid), 1);
        chk("t3_rrise", 32'(evt_rise), 1);
        chk("t3_rts", 32'(evt_ts), 32'(dummy + 16'd3));
        tick();
        chk("t3_gap", 32'(evt_valid), 0);
        repeat (3) tick();
        chk("t3_flvl", 32'(level_out), 0);
        chk("t3_fval", 32'(evt_valid), 1);
        chk("t3_frise", 32'(evt_rise), 0);
        chk("t3_fts", 32'(evt_ts), 32'(dummy + 16'd7));
        evt_ready = 1'b0;

        // 4) ten edges into an 8-deep FIFO, then drain
        do_reset();
        for (int k = 0; k < 10; k++) begin
            edge_evt(1'b0, 1'b0, q[k]);
        end
        chk("t4_count", 32'(fifo_count), 8);
        chk("t4_ovf", 32'(overflow_cnt), 2);
        chk("t4_hold_ts", 32'(evt_ts), 3);
        tick();
        chk("t4_hold_ts2", 32'(evt_ts), 3);
        evt_ready = 1'b1;
        for (int k = 0; k < 8; k++) begin
            chk("t4_valid", 32'(evt_valid), 1);
            chk("t4_rise", 32'(evt_rise), 32'(k % 2 == 0));
            chk("t4_ts", 32'(evt_ts), 32'(q[k]));
            chk("t4_sts", 32'(s_ts), 32'(q[k][3:0]));
            tick();
        end
        evt_ready = 1'b0;
        chk("t4_empty", 32'(evt_valid), 0);
        chk("t4_cnt0", 32'(fifo_count), 0);
        chk("t4_ts0", 32'(evt_ts), 0);

        // 5) push+pop while full, then clear racing a drop
        for (int k = 0; k < 8; k++) begin
            edge_evt(1'b0, 1'b0, q[k]);
        end
        chk("t5_full", 32'(fifo_count), 8);
        edge_evt(1'b1, 1'b0, q[8]);
        chk("t5_cnt", 32'(fifo_count), 8);
        chk("t5_ovf", 32'(overflow_cnt), 2);
        evt_ready = 1'b1;
        for (int k = 1; k < 9; k++) begin
            chk("t5_rise", 32'(evt_rise), 32'(k % 2 == 0));
            chk("t5_ts", 32'(evt_ts), 32'(q[k]));
            tick();
        end
        evt_ready = 1'b0;
        chk("t5_empty", 32'(evt_valid), 0);
        for (int k = 0; k < 8; k++) begin
            edge_evt(1'b0, 1'b0, dummy);
        end
        edge_evt(1'b0, 1'b1, dummy);
        chk("t5_clr_drop", 32'(overflow_cnt), 1);
        chk("t5_cnt8", 32'(fifo_count), 8);
        ovf_clr = 1'b1;
        tick();
        ovf_clr = 1'b0;
        chk("t5_clr", 32'(overflow_cnt), 0);

        // 6) reset with events queued; ts restarts
        sync_in = 1'b0;
        do_reset();
        for (int k = 0; k < 3; k++) begin
            edge_evt(1'b0, 1'b0, dummy);
        end
        chk("t6_cnt3", 32'(fifo_count), 3);
        sync_in = 1'b0;
        do_reset();
        chk("t6_valid", 32'(evt_valid), 0);
        chk("t6_cnt", 32'(fifo_count), 0);
        chk("t6_lvl", 32'(level_out), 0);
        edge_evt(1'b0, 1'b0, dummy);
        chk("t6_new_ts", 32'(evt_ts), 3);
        chk("t6_new_sts", 32'(s_ts), 3);
        chk("t6_new_rise", 32'(evt_rise), 1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
